// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : Bundle of the two requester ports and the memory-side port of
//             the data-memory arbiter. The slave modport is the arbiter view;
//             the master modport is the requester/memory environment view.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
    // requester 0
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [3:0]  p0_be;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    // requester 1
    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_be;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    // memory side
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        input  mem_rd,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_a, mem_wd, mem_we
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        output mem_rd,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_a, mem_wd, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port arbiter in front of a 1 KiB data-memory region.
//             Full-word writes complete in the grant cycle; partial writes
//             take one extra read-modify-write cycle. Accesses outside the
//             region are accepted but never write, and reads return zero.
//             Macro DMEM_ARB_RR_EN selects round-robin arbitration; when it
//             is undefined port 0 has fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h9600_0000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RMW  = 1'b1;
    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    logic [0:0]  state;
    logic [0:0]  next_state;

    logic        any_req;
    logic        win;          // 0 = port 0 wins, 1 = port 1 wins
    logic        win_we;
    logic [31:2] win_word;
    logic [31:0] win_wdata;
    logic [3:0]  win_be;
    logic        in_region;

    logic        grant;
    logic        rd_grant;
    logic        full_wr;
    logic        part_wr;

    logic [31:2] lat_word;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [1:0]  rvalid_q;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

`ifdef DMEM_ARB_RR_EN
    logic        prio;         // port favoured on contention
`endif

    // Pick the winning requester and route its request fields
    always_comb begin
        any_req = bus.p0_req | bus.p1_req;
`ifdef DMEM_ARB_RR_EN
        if (bus.p0_req && bus.p1_req)
            win = prio;
        else
            win = ~bus.p0_req;
`else
        win = ~bus.p0_req;
`endif
        win_we    = win ? bus.p1_we          : bus.p0_we;
        win_word  = win ? bus.p1_addr[31:2]  : bus.p0_addr[31:2];
        win_wdata = win ? bus.p1_wdata       : bus.p0_wdata;
        win_be    = win ? bus.p1_be          : bus.p0_be;
        in_region = (win_word[31:10] == BASE_ADDR[31:10]);
        grant     = (state == IDLE) && any_req && !reset;
        rd_grant  = grant && !win_we;
        full_wr   = grant && win_we && in_region && (win_be == BE_FULL);
        part_wr   = grant && win_we && in_region &&
                    (win_be != BE_FULL) && (win_be != BE_NONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: a partial in-region write detours through RMW
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (part_wr) next_state = RMW;
            RMW:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: reset forces every combinational output to its idle value
    always_comb begin
        bus.p0_gnt    = 1'b0;
        bus.p1_gnt    = 1'b0;
        bus.mem_a     = 32'h0;
        bus.mem_wd    = 32'h0;
        bus.mem_we    = 1'b0;
        bus.p0_rvalid = rvalid_q[0] & ~reset;
        bus.p1_rvalid = rvalid_q[1] & ~reset;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        bus.p0_gnt = ~win;
                        bus.p1_gnt = win;
                        bus.mem_a  = {win_word, 2'b00};
                        if (full_wr) begin
                            bus.mem_we = 1'b1;
                            bus.mem_wd = win_wdata;
                        end
                    end
                end
                RMW: begin
                    bus.mem_a  = {lat_word, 2'b00};
                    bus.mem_we = 1'b1;
                    for (int i = 0; i < 4; i++)
                        bus.mem_wd[i*8 +: 8] = lat_be[i] ? lat_wdata[i*8 +: 8]
                                                         : bus.mem_rd[i*8 +: 8];
                end
                default: ;
            endcase
        end
    end

    assign bus.p0_rdata = rdata0;
    assign bus.p1_rdata = rdata1;

    // Datapath registers: RMW latch, read return and read-valid pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_word  <= '0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
            rvalid_q  <= 2'b00;
            rdata0    <= 32'h0;
            rdata1    <= 32'h0;
        end else begin
            if (part_wr) begin
                lat_word  <= win_word;
                lat_wdata <= win_wdata;
                lat_be    <= win_be;
            end
            rvalid_q <= {rd_grant & win, rd_grant & ~win};
            if (rd_grant && !win)
                rdata0 <= in_region ? bus.mem_rd : 32'h0;
            if (rd_grant && win)
                rdata1 <= in_region ? bus.mem_rd : 32'h0;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Round-robin pointer: after each grant favour the other port
    always_ff @(posedge clk) begin
        if (reset)
            prio <= 1'b0;
        else if (grant)
            prio <= ~win;
    end
`endif

endmodule
`default_nettype wire
